// File: rtl/acc_bank_pkg.sv
// Shared constants for the multi-channel accumulator bank.
// MAC_ACC_WIDTH is the single source of truth for accumulator width.
package acc_bank_pkg;

  localparam int MAC_ACC_WIDTH = 32;
  localparam int MAC_DIN_WIDTH = 16;

  // Group framing states
  localparam logic [0:0] ACC_BANK_IDLE  = 1'b0;
  localparam logic [0:0] ACC_BANK_ACCUM = 1'b1;

endpackage

// File: rtl/acc_bank_lane.sv
// One accumulator channel: sign-extend, add, overflow detect,
// optional clamp and sticky overflow flag. Outputs are the post-add
// values of the current beat so the bank can capture them on a last beat.
module acc_lane
  import acc_bank_pkg::*;
#(
  parameter int DIN_WIDTH = MAC_DIN_WIDTH,
  parameter int ACC_WIDTH = MAC_ACC_WIDTH,
  parameter int SATURATE  = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_load,
  input  logic                        i_first,
  input  logic signed [ACC_WIDTH-1:0] i_init,
  input  logic                        i_mask,
  input  logic signed [DIN_WIDTH-1:0] i_din,
  output logic signed [ACC_WIDTH-1:0] o_sum,
  output logic                        o_ovf
);

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH-1:0] r_acc;
  logic                        r_ovf;
  logic signed [ACC_WIDTH-1:0] w_base;
  logic signed [ACC_WIDTH-1:0] w_add;
  logic signed [ACC_WIDTH-1:0] w_raw;
  logic                        w_of;

  // Clamp toward the operands' common sign when the add overflowed
  function automatic logic signed [ACC_WIDTH-1:0] sat_or_wrap(
    input logic signed [ACC_WIDTH-1:0] raw,
    input logic                        of,
    input logic                        neg
  );
    if (of && (SATURATE != 0)) return neg ? ACC_MIN : ACC_MAX;
    return raw;
  endfunction

  // A first beat adds onto the seed and restarts the sticky flag
  always_comb begin
    w_base = i_first ? i_init : r_acc;
    w_add  = i_mask ? ACC_WIDTH'(i_din) : '0;
    w_raw  = w_base + w_add;
    w_of   = (w_base[ACC_WIDTH-1] == w_add[ACC_WIDTH-1]) &&
             (w_raw[ACC_WIDTH-1] != w_base[ACC_WIDTH-1]);
    o_sum  = sat_or_wrap(w_raw, w_of, w_base[ACC_WIDTH-1]);
    o_ovf  = (i_first ? 1'b0 : r_ovf) | w_of;
  end

  // Accumulator and sticky flag advance only on accepted beats
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (i_load) begin
      r_acc <= o_sum;
      r_ovf <= o_ovf;
    end
  end

endmodule

// File: rtl/acc_bank.sv
// NUM_CH lock-step accumulators over framed beat groups, emitting one
// registered result per group over a valid/ready handshake.
module acc_bank
  import acc_bank_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DIN_WIDTH = MAC_DIN_WIDTH,
  parameter int ACC_WIDTH = MAC_ACC_WIDTH,
  parameter int SATURATE  = 1,
  parameter int CNT_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic signed [ACC_WIDTH-1:0]   init_val,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_first,
  input  logic                          in_last,
  input  logic [NUM_CH-1:0]             in_mask,
  input  logic [NUM_CH*DIN_WIDTH-1:0]   din,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_CH*ACC_WIDTH-1:0]   out_data,
  output logic [NUM_CH-1:0]             out_ovf,
  output logic [CNT_WIDTH-1:0]          out_count
);

  logic [0:0]                  r_state;
  logic [CNT_WIDTH-1:0]        r_count;
  logic                        r_out_valid;
  logic [NUM_CH*ACC_WIDTH-1:0] r_out_data;
  logic [NUM_CH-1:0]           r_out_ovf;
  logic [CNT_WIDTH-1:0]        r_out_count;

  logic                        w_accept;
  logic                        w_first;
  logic                        w_fire;
  logic [CNT_WIDTH-1:0]        w_cnt_next;
  logic [NUM_CH*ACC_WIDTH-1:0] w_sums;
  logic [NUM_CH-1:0]           w_ovfs;

  // Ready depends only on the output register, never on in_last
  assign in_ready = !r_out_valid | out_ready;
  assign w_accept = in_valid & in_ready;
  assign w_first  = in_first | (r_state == ACC_BANK_IDLE);
  assign w_fire   = r_out_valid & out_ready;

  // Beat counter next value, pinned at all-ones on long groups
  always_comb begin
    w_cnt_next = r_count;
    if (w_first)          w_cnt_next = CNT_WIDTH'(1);
    else if (!(&r_count)) w_cnt_next = r_count + 1'b1;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    acc_lane #(
      .DIN_WIDTH (DIN_WIDTH),
      .ACC_WIDTH (ACC_WIDTH),
      .SATURATE  (SATURATE)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_accept),
      .i_first (w_first),
      .i_init  (init_val),
      .i_mask  (in_mask[c]),
      .i_din   (din[c*DIN_WIDTH +: DIN_WIDTH]),
      .o_sum   (w_sums[c*ACC_WIDTH +: ACC_WIDTH]),
      .o_ovf   (w_ovfs[c])
    );
  end

  // Group framing FSM and beat counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ACC_BANK_IDLE;
      r_count <= '0;
    end else if (w_accept) begin
      r_state <= in_last ? ACC_BANK_IDLE : ACC_BANK_ACCUM;
      r_count <= w_cnt_next;
    end
  end

  // Result register: a last beat reloads it even while it is being read
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= '0;
      r_out_count <= '0;
    end else if (w_accept && in_last) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sums;
      r_out_ovf   <= w_ovfs;
      r_out_count <= w_cnt_next;
    end else if (w_fire) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ovf   = r_out_ovf;
  assign out_count = r_out_count;

endmodule

// File: tb/tb_acc_bank.sv
// Directed bench for acc_bank: a default-width bank plus two 16-bit banks
// (saturating and wrapping) fed from the same stimulus.
module tb_acc_bank;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  init_val = '0;
  logic         in_valid = 1'b0;
  logic         in_first = 1'b0;
  logic         in_last = 1'b0;
  logic [3:0]   in_mask = '0;
  logic [63:0]  din = '0;
  logic         out_ready = 1'b1;

  logic         in_ready, out_valid;
  logic [127:0] out_data;
  logic [3:0]   out_ovf;
  logic [7:0]   out_count;

  logic         b_in_ready, b_out_valid, c_in_ready, c_out_valid;
  logic [63:0]  b_out_data, c_out_data;
  logic [3:0]   b_out_ovf, c_out_ovf;
  logic [7:0]   b_out_count, c_out_count;

  int vectors = 0;
  int miscompares = 0;
  logic [127:0] fire_q[$];

  always #5 clk = ~clk;

  acc_bank dut (
    .clk(clk), .reset(reset), .init_val(init_val), .in_valid(in_valid),
    .in_ready(in_ready), .in_first(in_first), .in_last(in_last),
    .in_mask(in_mask), .din(din), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf), .out_count(out_count)
  );

  acc_bank #(.ACC_WIDTH(16), .SATURATE(1)) dut_sat (
    .clk(clk), .reset(reset), .init_val(init_val[15:0]), .in_valid(in_valid),
    .in_ready(b_in_ready), .in_first(in_first), .in_last(in_last),
    .in_mask(in_mask), .din(din), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_ovf(b_out_ovf), .out_count(b_out_count)
  );

  acc_bank #(.ACC_WIDTH(16), .SATURATE(0)) dut_wrap (
    .clk(clk), .reset(reset), .init_val(init_val[15:0]), .in_valid(in_valid),
    .in_ready(c_in_ready), .in_first(in_first), .in_last(in_last),
    .in_mask(in_mask), .din(din), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_data(c_out_data), .out_ovf(c_out_ovf), .out_count(c_out_count)
  );

  // Records every result of the default bank that will be taken at the next edge
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) fire_q.push_back(out_data);
  end

  function automatic logic [63:0] rep16(input logic [15:0] v);
    return {4{v}};
  endfunction

  // Present one beat and hold it until accepted; returns at posedge+1
  task automatic send(input logic f, input logic l, input logic [3:0] m,
                      input logic [63:0] d, input logic [31:0] iv);
    int n;
    n = 0;
    in_valid = 1'b1; in_first = f; in_last = l; in_mask = m; din = d; init_val = iv;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        vectors++; miscompares++;
        $display("FAIL send_timeout in_ready stayed %0b, required 1", in_ready);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    vectors++; if (out_data !== 128'd0) begin miscompares++; $display("FAIL rst_out_data got %h want 0", out_data); end
    vectors++; if (out_ovf !== 4'd0) begin miscompares++; $display("FAIL rst_out_ovf got %b want 0", out_ovf); end
    vectors++; if (out_count !== 8'd0) begin miscompares++; $display("FAIL rst_out_count got %0d want 0", out_count); end
    vectors++; if ({b_in_ready, c_in_ready} !== 2'b11) begin miscompares++; $display("FAIL rst_16b_in_ready got %b want 11", {b_in_ready, c_in_ready}); end
  endtask

  task automatic test_accum_4beat();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(i == 0, i == 3, 4'hF, rep16(16'd3), 32'd10);
      if (i == 2) begin
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL acc4_early_valid got %b want 0", out_valid); end
      end
    end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL acc4_valid got %b want 1", out_valid); end
    vectors++; if (out_data !== {4{32'd22}}) begin miscompares++; $display("FAIL acc4_data got %h want %h", out_data, {4{32'd22}}); end
    vectors++; if (out_count !== 8'd4) begin miscompares++; $display("FAIL acc4_count got %0d want 4", out_count); end
    vectors++; if (out_ovf !== 4'd0) begin miscompares++; $display("FAIL acc4_ovf got %b want 0", out_ovf); end
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL acc4_valid_clear got %b want 0", out_valid); end
  endtask

  task automatic test_mask();
    send(1'b1, 1'b1, 4'b0101, {16'd5, 16'd6, 16'd7, 16'd8}, 32'd0);
    vectors++; if (out_data !== {32'd0, 32'd6, 32'd0, 32'd8}) begin miscompares++; $display("FAIL mask_data got %h want %h", out_data, {32'd0, 32'd6, 32'd0, 32'd8}); end
    vectors++; if (out_count !== 8'd1) begin miscompares++; $display("FAIL mask_count got %0d want 1", out_count); end
  endtask

  task automatic test_saturate();
    // 32760 + 100 + 100: clamps at 32767 or wraps to 32960 - 65536 = -32576
    send(1'b1, 1'b0, 4'hF, rep16(16'd100), 32'd32760);
    send(1'b0, 1'b1, 4'hF, rep16(16'd100), 32'd32760);
    vectors++; if (b_out_data !== rep16(16'd32767)) begin miscompares++; $display("FAIL sat_pos_data got %h want %h", b_out_data, rep16(16'd32767)); end
    vectors++; if (b_out_ovf !== 4'hF) begin miscompares++; $display("FAIL sat_pos_ovf got %b want 1111", b_out_ovf); end
    vectors++; if (b_out_count !== 8'd2) begin miscompares++; $display("FAIL sat_pos_count got %0d want 2", b_out_count); end
    vectors++; if (c_out_data !== rep16(16'hFFFF & (-32576))) begin miscompares++; $display("FAIL wrap_pos_data got %h want %h", c_out_data, rep16(16'hFFFF & (-32576))); end
    vectors++; if (c_out_ovf !== 4'hF) begin miscompares++; $display("FAIL wrap_pos_ovf got %b want 1111", c_out_ovf); end
    vectors++; if (out_data !== {4{32'd32960}} || out_ovf !== 4'd0) begin miscompares++; $display("FAIL wide_no_ovf got %h/%b want %h/0000", out_data, out_ovf, {4{32'd32960}}); end
    // -32760 - 100 - 100: clamps at -32768 or wraps to 32676 then 32576
    send(1'b1, 1'b0, 4'hF, rep16(16'hFF9C), 32'hFFFF8008);
    send(1'b0, 1'b1, 4'hF, rep16(16'hFF9C), 32'hFFFF8008);
    vectors++; if (b_out_data !== rep16(16'h8000)) begin miscompares++; $display("FAIL sat_neg_data got %h want %h", b_out_data, rep16(16'h8000)); end
    vectors++; if (c_out_data !== rep16(16'd32576)) begin miscompares++; $display("FAIL wrap_neg_data got %h want %h", c_out_data, rep16(16'd32576)); end
    vectors++; if (c_out_ovf !== 4'hF || c_out_valid !== 1'b1) begin miscompares++; $display("FAIL wrap_neg_flags got ovf %b valid %b want 1111 1", c_out_ovf, c_out_valid); end
  endtask

  task automatic test_count_sat();
    for (int i = 0; i < 260; i++) send(i == 0, i == 259, 4'hF, 64'd0, 32'd0);
    vectors++; if (out_count !== 8'd255) begin miscompares++; $display("FAIL cnt_sat got %0d want 255", out_count); end
    vectors++; if (out_data !== 128'd0) begin miscompares++; $display("FAIL cnt_sat_data got %h want 0", out_data); end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    fire_q.delete();
    out_ready = 1'b0;
    fork
      begin
        for (int k = 1; k <= 3; k++) send(1'b1, 1'b1, 4'hF, rep16(16'(k)), 32'd0);
      end
      begin
        int n;
        n = 0;
        forever begin
          @(negedge clk);
          if (out_valid) break;
          n++;
          if (n > 20) begin
            vectors++; miscompares++;
            $display("FAIL b2b_wait_valid out_valid stayed %b, required 1", out_valid);
            break;
          end
        end
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_in_ready got %b want 0", in_ready); end
          vectors++; if (out_data !== {4{32'd1}} || out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_hold got %h/%b want %h/1", out_data, out_valid, {4{32'd1}}); end
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (fire_q.size() !== 3) begin miscompares++; $display("FAIL b2b_count got %0d want 3", fire_q.size()); end
    for (int k = 0; k < 3 && k < fire_q.size(); k++) begin
      vectors++; if (fire_q[k] !== {4{32'(k + 1)}}) begin miscompares++; $display("FAIL b2b_order[%0d] got %h want %h", k, fire_q[k], {4{32'(k + 1)}}); end
    end
  endtask

  task automatic test_abort();
    fire_q.delete();
    send(1'b1, 1'b0, 4'hF, rep16(16'd7), 32'd0);
    send(1'b0, 1'b0, 4'hF, rep16(16'd7), 32'd0);
    send(1'b0, 1'b0, 4'hF, rep16(16'd7), 32'd0);
    send(1'b1, 1'b0, 4'hF, rep16(16'd1), 32'd0);
    send(1'b0, 1'b1, 4'hF, rep16(16'd1), 32'd0);
    vectors++; if (out_data !== {4{32'd2}}) begin miscompares++; $display("FAIL abort_data got %h want %h", out_data, {4{32'd2}}); end
    vectors++; if (out_count !== 8'd2) begin miscompares++; $display("FAIL abort_count got %0d want 2", out_count); end
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (fire_q.size() !== 1) begin miscompares++; $display("FAIL abort_results got %0d want 1", fire_q.size()); end
  endtask

  task automatic test_reset_mid_group();
    out_ready = 1'b0;
    send(1'b1, 1'b1, 4'hF, rep16(16'd9), 32'd0);
    pulse_reset();
    vectors++; if (out_valid !== 1'b0 || out_data !== 128'd0) begin miscompares++; $display("FAIL rst_held_result got %b/%h want 0/0", out_valid, out_data); end
    out_ready = 1'b1;
    send(1'b1, 1'b0, 4'hF, rep16(16'd5), 32'd0);
    send(1'b0, 1'b0, 4'hF, rep16(16'd5), 32'd0);
    pulse_reset();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_valid got %b want 0", out_valid); end
    send(1'b0, 1'b1, 4'hF, rep16(16'd1), 32'd10);
    vectors++; if (out_data !== {4{32'd11}}) begin miscompares++; $display("FAIL rst_restart_data got %h want %h", out_data, {4{32'd11}}); end
    vectors++; if (out_count !== 8'd1) begin miscompares++; $display("FAIL rst_restart_count got %0d want 1", out_count); end
  endtask

  initial begin
    test_reset();
    test_accum_4beat();
    test_mask();
    test_saturate();
    test_count_sat();
    test_back_to_back();
    test_abort();
    test_reset_mid_group();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
